// File: rtl/router_pkt_tx_if.sv
// Handshake bundle between the router packet source and its user.
// ROUTER_PKT_TX_PARITY_ERR_EN adds the inj_parity_err request bit.
interface router_pkt_tx_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_dest;
    logic [5:0] cmd_len;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic       busy;
    logic [7:0] tx_data;
    logic       pkt_valid;
    logic       pkt_done;
    logic       cmd_err;
    logic       tx_active;
`ifdef ROUTER_PKT_TX_PARITY_ERR_EN
    logic       inj_parity_err;
`endif

    modport master (
`ifdef ROUTER_PKT_TX_PARITY_ERR_EN
        input  inj_parity_err,
`endif
        input  cmd_valid, cmd_dest, cmd_len,
        input  pl_data, pl_valid, busy,
        output cmd_ready, pl_ready,
        output tx_data, pkt_valid, pkt_done, cmd_err, tx_active
    );

    modport slave (
`ifdef ROUTER_PKT_TX_PARITY_ERR_EN
        output inj_parity_err,
`endif
        output cmd_valid, cmd_dest, cmd_len,
        output pl_data, pl_valid, busy,
        input  cmd_ready, pl_ready,
        input  tx_data, pkt_valid, pkt_done, cmd_err, tx_active
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Router input-port packet source: buffers payload, emits header/payload/parity.
// Optional ROUTER_PKT_TX_PARITY_ERR_EN: inverts parity of flagged packets.
module router_pkt_tx #(
    parameter int DEPTH      = 64,
    parameter int IFG_CYCLES = 3
) (
    input logic            clock,
    input logic            reset,
    router_pkt_tx_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, WAIT, HDR, PAY, PAR, GAP} state_t;

    state_t        state, state_d;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0] count;
    logic          up;
    logic [1:0]    dest_q;
    logic [5:0]    len_q, rem, rem_d;
    logic [7:0]    parity, parity_d, header;
    logic [3:0]    gap_cnt, gap_cnt_d;
    logic [7:0]    tx_q, tx_d;
    logic          pv_q, pv_d, done_q, done_d, err_q, err_d, act_q, act_d;
    logic          push, pop, accept, illegal, flip;

`ifdef ROUTER_PKT_TX_PARITY_ERR_EN
    logic inj_q;
    always_ff @(posedge clock) begin
        if (reset) inj_q <= 1'b0;
        else if (accept) inj_q <= bus.inj_parity_err;
    end
    assign flip = inj_q;
`else
    assign flip = 1'b0;
`endif

    assign header        = {len_q, dest_q};
    assign rd_nxt        = rd_ptr + AW'(1);
    assign bus.pl_ready  = up && (count != CW'(DEPTH));
    assign bus.cmd_ready = up && (state == IDLE);
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign illegal       = (bus.cmd_dest == 2'd3) || (bus.cmd_len == 6'd0);
    assign push          = bus.pl_valid && bus.pl_ready;

    assign bus.tx_data   = tx_q;
    assign bus.pkt_valid = pv_q;
    assign bus.pkt_done  = done_q;
    assign bus.cmd_err   = err_q;
    assign bus.tx_active = act_q;

    // Outputs are computed from the next state and registered, so busy
    // never reaches a pin combinationally.
    always_comb begin
        state_d   = state;
        tx_d      = tx_q;
        pv_d      = pv_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        pop       = 1'b0;
        parity_d  = parity;
        rem_d     = rem;
        gap_cnt_d = gap_cnt;
        unique case (state)
            IDLE: begin
                tx_d = 8'h00;
                pv_d = 1'b0;
                if (accept) begin
                    if (illegal) err_d = 1'b1;
                    else state_d = WAIT;
                end
            end
            WAIT: begin
                parity_d = 8'h00;
                if (count >= CW'(len_q)) begin
                    state_d = HDR;
                    tx_d    = header;
                    pv_d    = 1'b1;
                end
            end
            HDR: begin
                if (!bus.busy) begin
                    state_d  = PAY;
                    parity_d = parity ^ header;
                    rem_d    = len_q;
                    tx_d     = mem[rd_ptr];
                end
            end
            PAY: begin
                if (!bus.busy) begin
                    pop      = 1'b1;
                    parity_d = parity ^ tx_q;
                    rem_d    = rem - 6'd1;
                    if (rem == 6'd1) begin
                        state_d = PAR;
                        pv_d    = 1'b0;
                        tx_d    = parity_d ^ {8{flip}};
                    end else begin
                        tx_d = mem[rd_nxt];
                    end
                end
            end
            PAR: begin
                if (!bus.busy) begin
                    state_d   = GAP;
                    done_d    = 1'b1;
                    tx_d      = 8'h00;
                    gap_cnt_d = 4'(IFG_CYCLES - 1);
                end
            end
            GAP: begin
                if (gap_cnt == 4'd0) state_d = IDLE;
                else gap_cnt_d = gap_cnt - 4'd1;
            end
            default: state_d = IDLE;
        endcase
        act_d = (state_d == HDR) || (state_d == PAY) ||
                (state_d == PAR) || (state_d == GAP);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            up      <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            dest_q  <= 2'd0;
            len_q   <= 6'd0;
            rem     <= 6'd0;
            parity  <= 8'h00;
            gap_cnt <= 4'd0;
            tx_q    <= 8'h00;
            pv_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            state   <= state_d;
            up      <= 1'b1;
            rem     <= rem_d;
            parity  <= parity_d;
            gap_cnt <= gap_cnt_d;
            tx_q    <= tx_d;
            pv_q    <= pv_d;
            done_q  <= done_d;
            err_q   <= err_d;
            act_q   <= act_d;
            if (accept) begin
                dest_q <= bus.cmd_dest;
                len_q  <= bus.cmd_len;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_nxt;
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= bus.pl_data;
    end
endmodule
